// File: rtl/alu_pkg.sv
// alu_pkg
// Definitions shared by the ALU result queue and its flag generator.
//   - 3-bit ALU command encodings (CMD_*)
//   - bit positions of the 4-bit flag vector {zero, negative, carry, overflow}
//   - is_arith(): true for commands whose carry/overflow outputs are meaningful
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    localparam int FLAG_ZERO  = 3;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    // Only ADD and SUB produce a meaningful carry or overflow. SLT uses the
    // subtractor internally, but its carry/overflow are not architectural.
    function automatic logic is_arith(input logic [2:0] command);
        return (command == CMD_ADD) || (command == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen
// Combinational flag derivation for one ALU result.
// Ports:
//   result    [WIDTH-1:0] in   ALU result
//   carryout             in   raw ALU carryout
//   overflow             in   raw ALU overflow
//   command   [2:0]      in   command that produced the result
//   flags     [3:0]      out  {zero, negative, carry, overflow}
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result,
    input  logic             carryout,
    input  logic             overflow,
    input  logic [2:0]       command,
    output logic [3:0]       flags
);

    always_comb begin
        flags             = '0;
        flags[FLAG_ZERO]  = (result == '0);
        flags[FLAG_NEG]   = result[WIDTH-1];
        flags[FLAG_CARRY] = carryout && is_arith(command);
        flags[FLAG_OVF]   = overflow && is_arith(command);
    end

endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue
// Valid/ready FIFO holding ALU results plus derived flags between the execute
// stage and a consumer that may stall. Entries are presented strictly in order
// with no empty-queue bypass.
// Optional feature macro: ALU_STICKY_FLAGS_EN (accumulating sticky flag register).
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   in_valid / in_ready              producer handshake (in_ready is registered)
//   in_result, in_carryout,
//   in_overflow, in_command          ALU outputs captured at push
//   out_valid / out_ready            consumer handshake
//   out_result, out_flags            head entry {zero, negative, carry, overflow}
//   count                            current occupancy
//   sticky_flags, flag_clear         accumulated flags and their clear
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_carryout,
    input  logic                     in_overflow,
    input  logic [2:0]               in_command,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [3:0]               sticky_flags,
    input  logic                     flag_clear
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] result_mem [DEPTH];
    logic [3:0]       flag_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic [3:0]       push_flags;
    logic             push;
    logic             pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .result   (in_result),
        .carryout (in_carryout),
        .overflow (in_overflow),
        .command  (in_command),
        .flags    (push_flags)
    );

    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = result_mem[rd_ptr];
    assign out_flags  = flag_mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // in_ready is computed from the next occupancy so it is registered yet
    // still equals (count < DEPTH) every cycle after the first post-reset edge.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                result_mem[i] <= '0;
                flag_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                result_mem[wr_ptr] <= in_result;
                flag_mem[wr_ptr]   <= push_flags;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            in_ready <= (count_next < DEPTH_C);
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // A clear coinciding with a push leaves exactly that entry's flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_flags <= '0;
        end else if (flag_clear) begin
            sticky_flags <= push ? push_flags : 4'b0000;
        end else if (push) begin
            sticky_flags <= sticky_flags | push_flags;
        end
    end
`else
    logic unused_flag_clear;
    assign unused_flag_clear = flag_clear;
    assign sticky_flags      = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue
// Directed self-checking bench for alu_result_queue (WIDTH=32, DEPTH=4).
// Honours ALU_STICKY_FLAGS_EN for the sticky flag expectations.
module tb_alu_result_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_XOR = 3'd2, C_SLT = 3'd3;
    localparam logic [2:0] C_AND = 3'd4, C_NOR = 3'd6, C_OR = 3'd7;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carryout;
    logic             in_overflow;
    logic [2:0]       in_command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [$clog2(DEPTH):0] count;
    logic [3:0]       sticky_flags;
    logic             flag_clear;

    int vectors     = 0;
    int miscompares = 0;

    alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_carryout  (in_carryout),
        .in_overflow  (in_overflow),
        .in_command   (in_command),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count),
        .sticky_flags (sticky_flags),
        .flag_clear   (flag_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle 1 time unit past the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] res, input logic co,
                                 input logic ov, input logic [2:0] cmd,
                                 input logic ordy, input logic fclr);
        in_valid    = v;
        in_result   = res;
        in_carryout = co;
        in_overflow = ov;
        in_command  = cmd;
        out_ready   = ordy;
        flag_clear  = fclr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic [2:0]  cmd;
        logic [3:0]  flags;
    } flag_vec_t;

    flag_vec_t fv [7];
    logic [3:0] exp_sticky;

    initial begin
        fv[0] = '{32'h0000_0000, 1'b1, 1'b0, C_ADD, 4'b1010};
        fv[1] = '{32'h8000_0000, 1'b1, 1'b1, C_XOR, 4'b0100};
        fv[2] = '{32'h0000_0001, 1'b1, 1'b1, C_SLT, 4'b0000};
        fv[3] = '{32'hFFFF_FFFF, 1'b0, 1'b1, C_SUB, 4'b0101};
        fv[4] = '{32'h0000_0000, 1'b1, 1'b1, C_NOR, 4'b1000};
        fv[5] = '{32'h7FFF_FFFF, 1'b0, 1'b1, C_ADD, 4'b0001};
        fv[6] = '{32'h8000_0000, 1'b1, 1'b0, C_AND, 4'b0100};

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_result   = '0;
        in_carryout = 1'b0;
        in_overflow = 1'b0;
        in_command  = C_ADD;
        out_ready   = 1'b0;
        flag_clear  = 1'b0;

        // Reset held across edges
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_result", out_result, 0);

        reset_n = 1'b1;
        #1;
        checkOutput("rel_in_ready_pre_edge", 32'(in_ready), 0);
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        checkOutput("rel_in_ready_post_edge", 32'(in_ready), 1);

        // Single push/pop per flag vector; no bypass while pushing into empty
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            #1;
            checkOutput($sformatf("nobypass_%0d", i), 32'(out_valid), 0);
            applyStimulus(1, fv[i].res, fv[i].co, fv[i].ov, fv[i].cmd, 0, 0);
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 1);
            checkOutput($sformatf("vec%0d_result", i), out_result, fv[i].res);
            checkOutput($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(fv[i].flags));
            applyStimulus(0, 0, 0, 0, C_ADD, 1, 0);
            checkOutput($sformatf("vec%0d_drained", i), 32'(count), 0);
        end

        // Fill to DEPTH with consumer stalled
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 32'(i), 0, 0, C_OR, 0, 0);
            checkOutput($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
        end
        checkOutput("full_in_ready", 32'(in_ready), 0);
        checkOutput("full_head", out_result, 1);
        applyStimulus(1, 32'h5, 0, 0, C_OR, 0, 0);
        checkOutput("full_push_ignored", 32'(count), 4);
        checkOutput("stall_head_stable", out_result, 1);
        // Full with push request and pop: only the pop completes
        applyStimulus(1, 32'h5, 0, 0, C_OR, 1, 0);
        checkOutput("full_pushpop_count", 32'(count), 3);
        checkOutput("full_pushpop_ready", 32'(in_ready), 1);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            checkOutput($sformatf("drain_order_%0d", i), out_result, 32'(i));
            applyStimulus(0, 0, 0, 0, C_ADD, 1, 0);
        end
        checkOutput("drain_count", 32'(count), 0);
        checkOutput("drain_valid", 32'(out_valid), 0);

        // Steady state at count=2 with simultaneous push and pop
        applyStimulus(1, 32'h10, 0, 0, C_OR, 0, 0);
        applyStimulus(1, 32'h11, 0, 0, C_OR, 0, 0);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            #1;
            checkOutput($sformatf("pp_head_%0d", i), out_result, 32'h10 + 32'(i));
            applyStimulus(1, 32'h12 + 32'(i), 0, 0, C_OR, 1, 0);
            checkOutput($sformatf("pp_count_%0d", i), 32'(count), 2);
        end
        in_valid = 1'b0;
        checkOutput("pp_tail0", out_result, 32'h1A);
        applyStimulus(0, 0, 0, 0, C_ADD, 1, 0);
        checkOutput("pp_tail1", out_result, 32'h1B);
        applyStimulus(0, 0, 0, 0, C_ADD, 1, 0);
        checkOutput("pp_empty", 32'(count), 0);

        // Sticky flags: clear, accumulate, clear together with a push
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 1);
        checkOutput("sticky_cleared", 32'(sticky_flags), 0);
        applyStimulus(1, 32'h3, 0, 1, C_SUB, 0, 0);
        applyStimulus(1, 32'h5, 0, 0, C_ADD, 0, 0);
`ifdef ALU_STICKY_FLAGS_EN
        exp_sticky = 4'b0001;
`else
        exp_sticky = 4'b0000;
`endif
        checkOutput("sticky_accum", 32'(sticky_flags), 32'(exp_sticky));
        applyStimulus(1, 32'h0, 0, 0, C_ADD, 0, 1);
`ifdef ALU_STICKY_FLAGS_EN
        exp_sticky = 4'b1000;
`else
        exp_sticky = 4'b0000;
`endif
        checkOutput("sticky_clear_push", 32'(sticky_flags), 32'(exp_sticky));
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        checkOutput("pre_reset_count", 32'(count), 3);
        checkOutput("pre_reset_flags", 32'(out_flags), 32'(4'b0001));

        // Asynchronous reset mid-operation, observed before any clock edge
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_count", 32'(count), 0);
        checkOutput("async_out_valid", 32'(out_valid), 0);
        checkOutput("async_out_flags", 32'(out_flags), 0);
        checkOutput("async_out_result", out_result, 0);
        checkOutput("async_in_ready", 32'(in_ready), 0);
        checkOutput("async_sticky", 32'(sticky_flags), 0);
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, C_ADD, 0, 0);
        checkOutput("rerel_in_ready", 32'(in_ready), 1);
        checkOutput("rerel_out_valid", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Buffers ALU results and condition flags between the execute-stage ALU and the writeback/consumer stage. It accepts one result per cycle with its carryout, overflow and command, and derives zero and negative flags. It forces carry/overflow to 0 for non-arithmetic commands and presents entries in order through a valid/ready FIFO. It decouples the combinational ALU from a consumer that can stall.

## Interface
- WIDTH, 32, result width in bits.
- DEPTH, 4, FIFO entries; power of two, 2 to 16.
- clk  input  1  rising-edge clock; the block's only clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a result this cycle.
- in_ready  output  1  queue can accept an entry this cycle.
- in_result  input  WIDTH  ALU result.
- in_carryout  input  1  ALU carryout.
- in_overflow  input  1  ALU overflow.
- in_command  input  3  ALU command that produced the result.
- out_valid  output  1  head entry is available.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_result  output  WIDTH  head result.
- out_flags  output  4  head flags {zero, negative, carry, overflow}.
- count  output  $clog2(DEPTH)+1  current occupancy.
- sticky_flags  output  4  accumulated flags (see Configuration).
- flag_clear  input  1  clears sticky_flags.

## Operation
- Command encoding: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
- Push occurs when in_valid && in_ready.
- Pop occurs when out_valid && out_ready.
- Stored flags are computed at push:
  - zero = (in_result == 0).
  - negative = in_result[WIDTH-1].
  - carry = in_carryout && (in_command is ADD or SUB).
  - overflow = in_overflow && (in_command is ADD or SUB).
- For SLT, the result is stored as given. Carry and overflow are stored as 0.
- Storage is a circular buffer with write pointer, read pointer and count; both pointers wrap modulo DEPTH.
- in_ready is a register:
  - It is 0 in reset.
  - It becomes 1 on the first clk edge after reset_n deasserts.
  - Thereafter in_ready = (count < DEPTH). No combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_result and out_flags are driven from the head slot.
- Full with simultaneous push request and pop: no push (in_ready is low). The pop completes and count decrements.
- Non-full push and pop in the same cycle: both complete and count is unchanged.
- Empty: no bypass. out_valid stays 0 during the push cycle.
- Pop when empty is ignored. Push when full is ignored and in_valid is held by the producer.

## Timing
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- Throughput: one push and one pop per cycle.
- Reset (asynchronous, mid-operation included):
  - All entries are discarded.
  - count=0, both pointers 0, out_valid=0, in_ready=0.
  - out_result=0, out_flags=0, sticky_flags=0.
  - Storage slots reset to 0.
- out_result and out_flags remain stable while out_valid && !out_ready.

## Configuration
- ALU_STICKY_FLAGS_EN defined:
  - sticky_flags is a register. It ORs in the stored flags of every pushed entry.
  - flag_clear=1 sets it to 0 at the next edge.
  - Clear and push in the same cycle: the register takes exactly the pushed entry's flags.
- ALU_STICKY_FLAGS_EN undefined:
  - sticky_flags is tied to 0 and flag_clear is ignored.
  - No sticky register is instantiated.

## Structure
- Shared package alu_pkg holds:
  - the 3-bit command constants listed above;
  - flag bit indices FLAG_ZERO=3, FLAG_NEG=2, FLAG_CARRY=1, FLAG_OVF=0.
- One sub-module, alu_flag_gen: combinational; takes in_result, in_carryout, in_overflow, in_command and produces the 4-bit flags.
- Pointer, count, in_ready and sticky logic live in the top module.

## Test plan
- Reset release, then push ADD result 0x00000000 with carryout=1 -> in_ready=0 during reset and 1 one edge after release. Next cycle out_valid=1, out_result=0, out_flags=4'b1010.
- Push XOR result 0x80000000 with in_carryout=1 and in_overflow=1 -> out_flags=4'b0100 (carry and overflow masked).
- Hold out_ready=0 and push 4 entries (0x1, 0x2, 0x3, 0x4) -> count=4 and in_ready=0. A fifth push is not accepted. Then out_ready=1 for 4 cycles -> outputs 0x1..0x4 in order and count returns to 0.
- At count=2, push and pop together for 10 cycles -> count stays 2, pointers wrap, and output order is preserved.
- With ALU_STICKY_FLAGS_EN: push SUB with overflow=1, then ADD 0x5 -> sticky_flags=4'b0001. Assert flag_clear together with a push of 0x0 -> sticky_flags=4'b1000.
- Assert reset_n low with 3 entries queued -> count=0, out_valid=0 and out_flags=0 immediately, without waiting for a clk edge.
